picosoc_iomem_decoder: RTL and testbench
========================================

Name: picosoc_iomem_decoder

Overview:
- Parametrised successor to the fixed SoC-level address decode and read-data mux.
- Sits between the CPU's external I/O memory port and N peripheral slave channels.
- Decodes a base-relative slot index, registers the request into one slave channel and returns that slave's read data.
- Adds behaviour the fixed decode lacks: error response for unmapped slots, a per-transaction watchdog timeout, and abort when the master withdraws its request.

Parameters:
- NUM_SLAVES, 4, number of slave channels (1..16).
- BASE_ADDR, 32'h0300_0000, start of the decoded window.
- SLOT_BITS, 20, log2 of the bytes per slave slot (slot n = BASE_ADDR + n<<SLOT_BITS).
- TIMEOUT, 255, cycles in ACTIVE before the watchdog fires; 0 disables the watchdog.
- ERR_RDATA, 32'hDEAD_BEEF, m_rdata value returned on any error response.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m_valid  in  1  master request
- m_ready  out  1  one-cycle completion pulse
- m_wstrb  in  4  byte write strobes; 0 means read
- m_addr  in  32  byte address
- m_wdata  in  32  write data
- m_rdata  out  32  read data, valid while m_ready=1
- m_err  out  1  error flag, valid while m_ready=1
- s_valid  out  NUM_SLAVES  one-hot slave request
- s_ready  in  NUM_SLAVES  per-slave completion
- s_rdata  in  32*NUM_SLAVES  per-slave read data, slave n at bits [32n+31:32n]
- s_addr  out  32  latched address (shared by all slaves)
- s_wstrb  out  4  latched strobes
- s_wdata  out  32  latched write data
- timeout_irq  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset: state IDLE. All outputs are 0: m_ready, m_err, m_rdata, s_valid, s_addr, s_wstrb, s_wdata, timeout_irq. Watchdog counter is 0.
- Decode:
  - hit = m_addr in [BASE_ADDR, BASE_ADDR + NUM_SLAVES<<SLOT_BITS).
  - idx = (m_addr - BASE_ADDR) >> SLOT_BITS, truncated to clog2(NUM_SLAVES) bits.
  - Subtraction is 32-bit unsigned; an address below BASE_ADDR is a miss, not a wrap-around hit.
- IDLE:
  - m_valid && hit: latch addr/wstrb/wdata/idx, set s_valid[idx] at the next edge, clear the counter, go to ACTIVE.
  - m_valid && !hit: go to DONE with m_err=1 and m_rdata=ERR_RDATA. m_ready is high on the cycle after the request; no slave sees a request.
- ACTIVE:
  - s_valid[idx] is held. Counter increments each cycle and saturates.
  - s_ready[idx]=1: capture s_rdata[idx], drop s_valid, go to DONE with m_err=0.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: drop s_valid, pulse timeout_irq, go to DONE with m_err=1 and ERR_RDATA.
  - Else if m_valid=0 (abort): drop s_valid, go to IDLE with no m_ready. A late s_ready from the aborted slave is ignored.
  - s_ready on non-selected channels is always ignored.
  - s_ready and timeout in the same cycle: s_ready wins, no irq.
- DONE: m_ready=1 for exactly one cycle with registered m_rdata/m_err, then IDLE. Requests are not sampled in DONE, so back-to-back requests are accepted from the following IDLE cycle.
- Latency:
  - Request at cycle 0 gives s_valid at cycle 1.
  - s_ready at cycle k gives m_ready at cycle k+1.
  - Minimum hit latency is 2 cycles (s_ready in cycle 1); a miss completes in 1 cycle.
- s_addr/s_wstrb/s_wdata are held stable from ACTIVE entry through DONE. s_wstrb is cleared to 0 when returning to IDLE.
- Counter width is clog2(TIMEOUT+1), minimum 1.
- reset mid-transaction returns to IDLE at the next edge and drops s_valid immediately. No m_ready is issued for the in-flight transaction.

Decomposition:
- Package picosoc_bus_pkg holds:
  - state enum (IDLE, ACTIVE, DONE)
  - default ERR_RDATA constant
  - bus word/strobe width constants
- One sub-module, picosoc_bus_watchdog: clear, enable, saturating count, fire output, parametrised by TIMEOUT. The decoder instantiates it once.

Test Plan:
- Read slot 2 (m_addr=0x0320_0010), slave 2 asserts s_ready 3 cycles after s_valid with rdata 0x1234_5678 -> s_valid=4'b0100 and s_addr=0x0320_0010; m_ready one cycle later with m_rdata=0x1234_5678, m_err=0.
- Write m_addr=0x0300_0004, wstrb=4'b0011, wdata=0xAABB_CCDD -> slave 0 sees s_wstrb=4'b0011 and s_wdata=0xAABB_CCDD stable until s_ready; m_ready pulses once.
- Unmapped addresses 0x0340_0000 and 0x02FF_FFFC -> m_ready on the next cycle with m_err=1, m_rdata=0xDEAD_BEEF; s_valid stays 0.
- Slave 1 never responds, TIMEOUT=255 -> timeout_irq and s_valid drop 255 cycles after s_valid rises; m_ready=1, m_err=1 on the following cycle; a late s_ready[1] is ignored.
- m_valid deasserted 2 cycles into ACTIVE -> s_valid drops, no m_ready; a new request to slot 3 is then served normally.
- reset asserted while ACTIVE, and s_ready coinciding with a timeout -> all outputs are 0 after the reset edge; in the coincidence case m_err=0 and timeout_irq stays 0.

Source files
------------

// File: rtl/picosoc_bus_pkg.sv
// Shared definitions for the PicoSoC I/O memory decoder and its watchdog.
package picosoc_bus_pkg;

   // Bus geometry of the CPU's external I/O memory port.
   localparam int BUS_DW = 32;
   localparam int BUS_SW = BUS_DW / 8;

   // Read data returned on any error response unless overridden.
   localparam logic [BUS_DW-1:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

   // Transaction state of the decoder.
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE,
      ST_DONE
   } bus_state_e;

   // Bits needed to hold values 0..v-1, never less than one.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/picosoc_bus_watchdog.sv
// Per-transaction watchdog: counts cycles while enabled, saturates, and
// flags the cycle in which the count reaches TIMEOUT-1. TIMEOUT=0 disables it.
module picosoc_bus_watchdog
   import picosoc_bus_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_fire
);

   localparam int               CNT_W   = clog2_min1(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] FIRE_AT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] r_count;

   // Saturating cycle counter, cleared whenever no transaction is in flight.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous, so it lives inside the clocked block and
      // the sensitivity list carries the clock only.
      if (reset || i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != CNT_MAX)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_fire = (TIMEOUT != 0) && i_enable && (r_count == FIRE_AT);

endmodule

// File: rtl/picosoc_iomem_decoder.sv
// Address decoder and read-data mux between the CPU I/O memory port and
// NUM_SLAVES slave channels, with error response for unmapped slots,
// a watchdog timeout and master-abort support.
module picosoc_iomem_decoder
   import picosoc_bus_pkg::*;
#(
   parameter int                NUM_SLAVES = 4,
   parameter logic [BUS_DW-1:0] BASE_ADDR  = 32'h0300_0000,
   parameter int                SLOT_BITS  = 20,
   parameter int                TIMEOUT    = 255,
   parameter logic [BUS_DW-1:0] ERR_RDATA  = DEFAULT_ERR_RDATA
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         m_valid,
   output logic                         m_ready,
   input  logic [BUS_SW-1:0]            m_wstrb,
   input  logic [BUS_DW-1:0]            m_addr,
   input  logic [BUS_DW-1:0]            m_wdata,
   output logic [BUS_DW-1:0]            m_rdata,
   output logic                         m_err,
   output logic [NUM_SLAVES-1:0]        s_valid,
   input  logic [NUM_SLAVES-1:0]        s_ready,
   input  logic [BUS_DW*NUM_SLAVES-1:0] s_rdata,
   output logic [BUS_DW-1:0]            s_addr,
   output logic [BUS_SW-1:0]            s_wstrb,
   output logic [BUS_DW-1:0]            s_wdata,
   output logic                         timeout_irq
);

   localparam int          IDX_W  = clog2_min1(NUM_SLAVES);
   // One extra bit so a window reaching the top of the address space
   // cannot overflow the limit compare.
   localparam logic [32:0] WINDOW = 33'(NUM_SLAVES) << SLOT_BITS;

   bus_state_e             r_state;
   logic [IDX_W-1:0]       r_idx;
   logic [NUM_SLAVES-1:0]  r_s_valid;
   logic [BUS_DW-1:0]      r_s_addr;
   logic [BUS_SW-1:0]      r_s_wstrb;
   logic [BUS_DW-1:0]      r_s_wdata;
   logic                   r_m_ready;
   logic                   r_m_err;
   logic [BUS_DW-1:0]      r_m_rdata;
   logic                   r_timeout_irq;

   logic [BUS_DW-1:0]      w_offset;
   logic                   w_hit;
   logic [IDX_W-1:0]       w_idx;
   logic [NUM_SLAVES-1:0]  w_onehot;
   logic                   w_sel_ready;
   logic [BUS_DW-1:0]      w_sel_rdata;
   logic                   w_fire;

   // Decode: an address below BASE_ADDR is a miss even though the
   // unsigned difference would wrap into the window.
   assign w_offset    = m_addr - BASE_ADDR;
   assign w_hit       = (m_addr >= BASE_ADDR) && ({1'b0, w_offset} < WINDOW);
   assign w_idx       = IDX_W'(w_offset >> SLOT_BITS);
   assign w_onehot    = NUM_SLAVES'(1) << w_idx;

   // Only the latched slave's handshake and data are ever looked at.
   assign w_sel_ready = s_ready[r_idx];
   assign w_sel_rdata = s_rdata[r_idx*BUS_DW +: BUS_DW];

   picosoc_bus_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk      (clk),
      .reset    (reset),
      .i_clear  (r_state != ST_ACTIVE),
      .i_enable (r_state == ST_ACTIVE),
      .o_fire   (w_fire)
   );

   // Transaction FSM with registered master and slave side outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_idx         <= '0;
         r_s_valid     <= '0;
         r_s_addr      <= '0;
         r_s_wstrb     <= '0;
         r_s_wdata     <= '0;
         r_m_ready     <= 1'b0;
         r_m_err       <= 1'b0;
         r_m_rdata     <= '0;
         r_timeout_irq <= 1'b0;
      end else begin
         // NOTE: pulse outputs default low here and are raised only by the
         // branch that needs them; later non-blocking writes win.
         r_m_ready     <= 1'b0;
         r_timeout_irq <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (m_valid) begin
                  if (w_hit) begin
                     r_idx     <= w_idx;
                     r_s_valid <= w_onehot;
                     r_s_addr  <= m_addr;
                     r_s_wstrb <= m_wstrb;
                     r_s_wdata <= m_wdata;
                     r_state   <= ST_ACTIVE;
                  end else begin
                     r_m_ready <= 1'b1;
                     r_m_err   <= 1'b1;
                     r_m_rdata <= ERR_RDATA;
                     r_state   <= ST_DONE;
                  end
               end
            end
            ST_ACTIVE: begin
               // Slave completion outranks the watchdog, which outranks abort.
               if (w_sel_ready) begin
                  r_s_valid <= '0;
                  r_m_ready <= 1'b1;
                  r_m_err   <= 1'b0;
                  r_m_rdata <= w_sel_rdata;
                  r_state   <= ST_DONE;
               end else if (w_fire) begin
                  r_s_valid     <= '0;
                  r_timeout_irq <= 1'b1;
                  r_m_ready     <= 1'b1;
                  r_m_err       <= 1'b1;
                  r_m_rdata     <= ERR_RDATA;
                  r_state       <= ST_DONE;
               end else if (!m_valid) begin
                  r_s_valid <= '0;
                  r_s_wstrb <= '0;
                  r_state   <= ST_IDLE;
               end
            end
            ST_DONE: begin
               r_m_err   <= 1'b0;
               r_m_rdata <= '0;
               r_s_wstrb <= '0;
               r_state   <= ST_IDLE;
            end
            default: begin
               r_s_valid <= '0;
               r_s_wstrb <= '0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   // Slave request is withdrawn as soon as reset is seen, not one edge later.
   assign s_valid     = reset ? '0 : r_s_valid;
   assign s_addr      = r_s_addr;
   assign s_wstrb     = r_s_wstrb;
   assign s_wdata     = r_s_wdata;
   assign m_ready     = r_m_ready;
   assign m_err       = r_m_err;
   assign m_rdata     = r_m_rdata;
   assign timeout_irq = r_timeout_irq;

endmodule

// File: tb/tb_picosoc_iomem_decoder.sv
// Self-checking bench for picosoc_iomem_decoder: a transaction-level model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_picosoc_iomem_decoder;

   localparam int          N    = 4;
   localparam logic [31:0] BASE = 32'h0300_0000;
   localparam int          SB   = 20;
   localparam int          TO   = 255;
   localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

   logic            clk;
   logic            reset;
   logic            m_valid;
   logic            m_ready;
   logic [3:0]      m_wstrb;
   logic [31:0]     m_addr;
   logic [31:0]     m_wdata;
   logic [31:0]     m_rdata;
   logic            m_err;
   logic [N-1:0]    s_valid;
   logic [N-1:0]    s_ready;
   logic [32*N-1:0] s_rdata;
   logic [31:0]     s_addr;
   logic [3:0]      s_wstrb;
   logic [31:0]     s_wdata;
   logic            timeout_irq;

   picosoc_iomem_decoder #(
      .NUM_SLAVES (N),
      .BASE_ADDR  (BASE),
      .SLOT_BITS  (SB),
      .TIMEOUT    (TO),
      .ERR_RDATA  (ERRD)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_wstrb     (m_wstrb),
      .m_addr      (m_addr),
      .m_wdata     (m_wdata),
      .m_rdata     (m_rdata),
      .m_err       (m_err),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_rdata     (s_rdata),
      .s_addr      (s_addr),
      .s_wstrb     (s_wstrb),
      .s_wdata     (s_wdata),
      .timeout_irq (timeout_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   logic        exp_ready, exp_err, exp_irq, exp_hold, exp_zero;
   logic [31:0] exp_rdata, exp_addr, exp_wdata;
   logic [3:0]  exp_wstrb;
   logic [N-1:0] exp_svalid;
   bit          model_live = 1'b0;
   bit          in_txn;
   bit          was_resp;
   int          slot;
   int          waited;
   longint      mdl_a, mdl_lo, mdl_hi;

   task automatic model_respond(input logic err, input logic [31:0] data);
      exp_ready = 1'b1;
      exp_err   = err;
      exp_rdata = data;
   endtask

   always @(posedge clk) begin : model
      if (reset) begin
         exp_ready = 0; exp_err = 0; exp_irq = 0; exp_hold = 0; exp_zero = 1;
         exp_rdata = 0; exp_addr = 0; exp_wdata = 0; exp_wstrb = 0; exp_svalid = 0;
         in_txn = 0; waited = 0; slot = 0;
         model_live = 1'b1;
      end else begin
         was_resp  = exp_ready;
         exp_zero  = 0;
         exp_ready = 0; exp_err = 0; exp_irq = 0; exp_rdata = 0;
         if (was_resp) begin
            exp_wstrb = 0;
            exp_hold  = 0;
         end else if (in_txn) begin
            waited++;
            if (s_ready[slot]) begin
               in_txn = 0; exp_svalid = 0;
               model_respond(1'b0, s_rdata[slot*32 +: 32]);
            end else if (TO != 0 && waited == TO) begin
               in_txn = 0; exp_svalid = 0; exp_irq = 1;
               model_respond(1'b1, ERRD);
            end else if (!m_valid) begin
               in_txn = 0; exp_svalid = 0; exp_wstrb = 0; exp_hold = 0;
            end
         end else if (m_valid) begin
            mdl_a  = longint'(m_addr);
            mdl_lo = longint'(BASE);
            mdl_hi = mdl_lo + (longint'(N) << SB);
            if (mdl_a >= mdl_lo && mdl_a < mdl_hi) begin
               slot       = int'((mdl_a - mdl_lo) >> SB);
               in_txn     = 1; waited = 0;
               exp_svalid = N'(1 << slot);
               exp_addr   = m_addr; exp_wstrb = m_wstrb; exp_wdata = m_wdata;
               exp_hold   = 1;
            end else begin
               model_respond(1'b1, ERRD);
            end
         end
      end
   end

   // Compare process: outputs sampled 2 time units after every rising edge.
   always @(posedge clk) begin : compare
      #2;
      if (model_live) begin
         if (exp_zero) begin
            check("cmp rst m_ready", 32'(m_ready), 32'(0));
            check("cmp rst m_err", 32'(m_err), 32'(0));
            check("cmp rst m_rdata", m_rdata, 32'(0));
            check("cmp rst s_valid", 32'(s_valid), 32'(0));
            check("cmp rst s_addr", s_addr, 32'(0));
            check("cmp rst s_wstrb", 32'(s_wstrb), 32'(0));
            check("cmp rst s_wdata", s_wdata, 32'(0));
            check("cmp rst irq", 32'(timeout_irq), 32'(0));
         end else begin
            check("cmp m_ready", 32'(m_ready), 32'(exp_ready));
            check("cmp s_valid", 32'(s_valid), 32'(exp_svalid));
            check("cmp timeout_irq", 32'(timeout_irq), 32'(exp_irq));
            check("cmp s_wstrb", 32'(s_wstrb), 32'(exp_wstrb));
            if (exp_ready) begin
               check("cmp m_rdata", m_rdata, exp_rdata);
               check("cmp m_err", 32'(m_err), 32'(exp_err));
            end
            if (exp_hold) begin
               check("cmp s_addr", s_addr, exp_addr);
               check("cmp s_wdata", s_wdata, exp_wdata);
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #3;
      end
   endtask

   task automatic req(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd);
      m_valid = 1'b1; m_addr = a; m_wstrb = ws; m_wdata = wd;
   endtask

   task automatic end_req();
      m_valid = 1'b0; m_wstrb = 4'b0;
   endtask

   logic [31:0] miss_addr [2] = '{32'h0340_0000, 32'h02FF_FFFC};
   int          pulses;

   initial begin
      reset = 1'b1; m_valid = 1'b0; m_wstrb = '0; m_addr = '0; m_wdata = '0;
      s_ready = '0; s_rdata = '0;
      tick(3);
      reset = 1'b0;
      check("reset m_ready", 32'(m_ready), 32'(0));
      check("reset s_valid", 32'(s_valid), 32'(0));
      tick();

      // Read slot 2, slave answers 3 cycles after s_valid rises.
      req(32'h0320_0010, 4'b0000, 32'h0);
      tick();
      check("rd s_valid", 32'(s_valid), 32'(4'b0100));
      check("rd s_addr", s_addr, 32'h0320_0010);
      tick(3);
      check("rd no early m_ready", 32'(m_ready), 32'(0));
      s_ready[2] = 1'b1; s_rdata[95:64] = 32'h1234_5678;
      tick();
      s_ready = '0; end_req();
      check("rd m_ready", 32'(m_ready), 32'(1));
      check("rd m_rdata", m_rdata, 32'h1234_5678);
      check("rd m_err", 32'(m_err), 32'(0));
      tick();
      check("rd m_ready low", 32'(m_ready), 32'(0));

      // Write slot 0, strobes and data held until the slave completes.
      req(32'h0300_0004, 4'b0011, 32'hAABB_CCDD);
      tick();
      check("wr s_valid", 32'(s_valid), 32'(4'b0001));
      for (int i = 0; i < 3; i++) begin
         check("wr s_wstrb hold", 32'(s_wstrb), 32'(4'b0011));
         check("wr s_wdata hold", s_wdata, 32'hAABB_CCDD);
         tick();
      end
      s_ready[0] = 1'b1;
      tick();
      s_ready = '0; end_req();
      pulses = int'(m_ready);
      check("wr s_wstrb in done", 32'(s_wstrb), 32'(4'b0011));
      tick();
      pulses += int'(m_ready);
      check("wr s_wstrb cleared", 32'(s_wstrb), 32'(0));
      tick();
      pulses += int'(m_ready);
      check("wr m_ready pulses", 32'(pulses), 32'(1));

      // Unmapped: just above the window and just below the base.
      foreach (miss_addr[i]) begin
         req(miss_addr[i], 4'b0000, 32'h0);
         tick();
         end_req();
         check("miss m_ready", 32'(m_ready), 32'(1));
         check("miss m_err", 32'(m_err), 32'(1));
         check("miss m_rdata", m_rdata, 32'hDEAD_BEEF);
         check("miss s_valid", 32'(s_valid), 32'(0));
         tick();
      end

      // Slave 1 never answers: watchdog fires after 255 active cycles.
      req(32'h0310_0000, 4'b0000, 32'h0);
      tick();
      check("to s_valid", 32'(s_valid), 32'(4'b0010));
      tick(254);
      check("to s_valid still", 32'(s_valid), 32'(4'b0010));
      check("to irq not yet", 32'(timeout_irq), 32'(0));
      tick();
      end_req();
      check("to s_valid dropped", 32'(s_valid), 32'(0));
      check("to irq", 32'(timeout_irq), 32'(1));
      check("to m_ready", 32'(m_ready), 32'(1));
      check("to m_err", 32'(m_err), 32'(1));
      check("to m_rdata", m_rdata, 32'hDEAD_BEEF);
      s_ready[1] = 1'b1;
      tick();
      check("to late s_ready ignored", 32'(m_ready), 32'(0));
      s_ready = '0;
      tick();

      // Abort two cycles into ACTIVE, then a normal request to slot 3.
      req(32'h0310_0008, 4'b0000, 32'h0);
      tick(2);
      m_valid = 1'b0;
      tick();
      check("abort s_valid", 32'(s_valid), 32'(0));
      check("abort m_ready", 32'(m_ready), 32'(0));
      s_ready[1] = 1'b1;
      tick();
      check("abort late s_ready", 32'(m_ready), 32'(0));
      s_ready = '0;
      req(32'h033F_FFFC, 4'b0000, 32'h0);
      tick();
      check("slot3 s_valid", 32'(s_valid), 32'(4'b1000));
      check("slot3 s_addr", s_addr, 32'h033F_FFFC);
      s_ready = 4'b0001; s_rdata[31:0] = 32'h0BAD_0BAD; s_rdata[127:96] = 32'h5107_0003;
      tick();
      check("slot3 foreign ready", 32'(m_ready), 32'(0));
      check("slot3 s_valid held", 32'(s_valid), 32'(4'b1000));
      s_ready = 4'b1000;
      tick();
      s_ready = '0; end_req();
      check("slot3 m_ready", 32'(m_ready), 32'(1));
      check("slot3 m_rdata", m_rdata, 32'h5107_0003);
      check("slot3 m_err", 32'(m_err), 32'(0));
      tick();

      // Reset while ACTIVE.
      req(32'h0300_0000, 4'b1111, 32'h1122_3344);
      tick();
      check("rst s_valid before", 32'(s_valid), 32'(4'b0001));
      reset = 1'b1;
      tick();
      end_req();
      check("rst m_ready", 32'(m_ready), 32'(0));
      check("rst m_err", 32'(m_err), 32'(0));
      check("rst m_rdata", m_rdata, 32'(0));
      check("rst s_valid", 32'(s_valid), 32'(0));
      check("rst s_addr", s_addr, 32'(0));
      check("rst s_wstrb", 32'(s_wstrb), 32'(0));
      check("rst s_wdata", s_wdata, 32'(0));
      check("rst irq", 32'(timeout_irq), 32'(0));
      reset = 1'b0;
      tick();
      check("rst no m_ready", 32'(m_ready), 32'(0));

      // s_ready in the same cycle the watchdog would fire: completion wins.
      req(32'h0320_0000, 4'b0000, 32'h0);
      tick();
      tick(254);
      s_ready[2] = 1'b1; s_rdata[95:64] = 32'hCAFE_0001;
      tick();
      s_ready = '0; end_req();
      check("coinc m_ready", 32'(m_ready), 32'(1));
      check("coinc m_err", 32'(m_err), 32'(0));
      check("coinc irq", 32'(timeout_irq), 32'(0));
      check("coinc m_rdata", m_rdata, 32'hCAFE_0001);
      tick();
      check("coinc irq after", 32'(timeout_irq), 32'(0));
      tick(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Hard bound on the whole run.
   initial begin
      #200000;
      $display("FAIL global time limit reached");
      $fatal(1, "simulation time limit");
   end

endmodule
